// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution sequencer:
// 32-bit signed operands, 3-bit opcode enum, 5-bit slot address.
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

endpackage

// File: rtl/instr_exec_seq_if.sv
// Register-read and result-handshake bundle between the execution sequencer
// (master) and the instruction register / checker side (slave).
interface instr_exec_seq_if #(
    parameter int RES_W = 64
) ();
    import instr_register_pkg::*;

    address_t                 read_pointer;
    instruction_t             instruction_word;
    logic signed [RES_W-1:0]  result;
    opcode_t                  result_opc;
    logic                     result_valid;
    logic                     result_ready;
    logic                     div_err;

    modport master (
        output read_pointer,
        input  instruction_word,
        output result,
        output result_opc,
        output result_valid,
        input  result_ready,
        output div_err
    );

    modport slave (
        input  read_pointer,
        output instruction_word,
        input  result,
        input  result_opc,
        input  result_valid,
        output result_ready,
        input  div_err
    );

endinterface

// File: rtl/instr_exec_seq.sv
// Execution sequencer: walks a slot range of the instruction register, executes
// each word and offers results over valid/ready. Define INSTR_EXEC_DIV_EN for a real divider.
module instr_exec_seq
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int RES_W = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  address_t       first_addr,
    input  logic [5:0]     count,
    output logic           busy,
    output logic           done,
    instr_exec_seq_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT,
        DONE
    } state_t;

    state_t                   state;
    address_t                 ptr;
    address_t                 ptr_next;
    logic [5:0]               remaining;
    instruction_t             instr_q;

    logic signed [RES_W-1:0]  a_ext;
    logic signed [RES_W-1:0]  b_ext;
    logic signed [RES_W-1:0]  exec_res;
    logic                     exec_err;

    assign a_ext = {{(RES_W-32){instr_q.op_a[31]}}, instr_q.op_a};
    assign b_ext = {{(RES_W-32){instr_q.op_b[31]}}, instr_q.op_b};

    assign ptr_next = (ptr == address_t'(DEPTH-1)) ? '0 : ptr + 1'b1;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        exec_res = '0;
        exec_err = 1'b0;
        case (instr_q.opc)
            ZERO:  exec_res = '0;
            PASSA: exec_res = a_ext;
            PASSB: exec_res = b_ext;
            ADD:   exec_res = a_ext + b_ext;
            SUB:   exec_res = a_ext - b_ext;
            MULT:  exec_res = a_ext * b_ext;
            DIV, MOD: begin
`ifdef INSTR_EXEC_DIV_EN
                if (b_ext == '0) begin
                    exec_err = 1'b1;
                end else if (instr_q.opc == DIV) begin
                    exec_res = a_ext / b_ext;
                end else begin
                    exec_res = a_ext % b_ext;
                end
`else
                exec_err = 1'b1;
`endif
            end
            default: begin
                exec_res = '0;
                exec_err = 1'b0;
            end
        endcase
    end

    // read_pointer is only reloaded on entry to FETCH so it holds during EXEC/OUT/DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= '0;
            remaining         <= '0;
            instr_q           <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            bus.read_pointer  <= '0;
            bus.result        <= '0;
            bus.result_opc    <= ZERO;
            bus.result_valid  <= 1'b0;
            bus.div_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= first_addr;
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            bus.read_pointer <= first_addr;
                            state            <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    instr_q <= bus.instruction_word;
                    state   <= EXEC;
                end
                EXEC: begin
                    bus.result       <= exec_res;
                    bus.result_opc   <= instr_q.opc;
                    bus.div_err      <= exec_err;
                    bus.result_valid <= 1'b1;
                    state            <= OUT;
                end
                OUT: begin
                    if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        ptr              <= ptr_next;
                        remaining        <= remaining - 1'b1;
                        if (remaining > 6'd1) begin
                            bus.read_pointer <= ptr_next;
                            state            <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_exec_seq.md
# instr_exec_seq

- Execution sequencer directly downstream of the instruction register.
- After a start pulse, walks a contiguous range of register slots by driving the register's read pointer and decoding each returned instruction word.
- Computes each result and hands it to the checker/scoreboard side over a valid/ready handshake.
- Types come from instr_register_pkg: operands 32-bit signed, opcode enum (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD), address 5-bit.

## Interface
- DEPTH, 32, number of register slots; pointer wraps modulo DEPTH.
- RES_W, 64, result width (signed).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a sequence; ignored unless idle.
- first_addr  input  5  first slot to execute; sampled on accepted start.
- count  input  6  number of instructions, 0..32; sampled on accepted start.
- read_pointer  output  5  slot address to the instruction register.
- instruction_word  input  instruction_t  {opc, op_a, op_b} at read_pointer; combinational from the register.
- result  output  RES_W  signed result of the current instruction.
- result_opc  output  opcode_t  opcode that produced result.
- result_valid  output  1  result/result_opc/div_err are valid.
- result_ready  input  1  consumer accepts the result.
- div_err  output  1  current result came from divide/mod by zero.
- busy  output  1  high from the accepted start through the DONE state inclusive.
- done  output  1  one-cycle pulse at the end of a sequence.

## Operation
- FSM states: IDLE, FETCH, EXEC, OUT, DONE.
- IDLE:
  - start=1 captures first_addr into ptr and count into remaining.
  - count=0 goes to DONE; otherwise goes to FETCH.
- FETCH:
  - read_pointer=ptr; instruction_word is registered at end of cycle.
  - Next state: EXEC.
- EXEC:
  - Result computed from the registered word into the result register.
  - Next state: OUT.
- OUT:
  - result_valid=1, held stable until result_ready=1.
  - On handshake: ptr=(ptr+1) mod DEPTH and remaining decrements.
  - Next state is FETCH if remaining>1, else DONE.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic, operands sign-extended to RES_W:
  - ZERO gives 0; PASSA gives a; PASSB gives b.
  - ADD gives a+b; SUB gives a-b; MULT gives the full 64-bit product.
  - DIV truncates toward zero; MOD result takes the dividend's sign.
  - b=0 on DIV/MOD gives result 0 and div_err=1.
  - Any opcode outside the enum gives result 0 and div_err=0.
- Wrap-around: first_addr=30, count=4 reads slots 30, 31, 0, 1.
- start while busy: ignored; no recapture.
- Reset (any time, including mid-sequence):
  - State returns to IDLE immediately.
  - read_pointer=0, result=0, result_opc=ZERO.
  - result_valid, div_err, busy and done all 0.

## Timing
- start accepted at edge N: FETCH during cycle N+1, EXEC N+2, result_valid high from cycle N+3.
- Steady state with result_ready held high: one result every 3 cycles.
- result_valid never drops without a handshake, except on reset.
- read_pointer holds its value outside FETCH.
- done asserts in the cycle after the last handshake. With count=0, done asserts in the cycle after start.
- busy falls in the cycle after done.

## Configuration
- INSTR_EXEC_DIV_EN defined: DIV/MOD implemented as specified above.
- INSTR_EXEC_DIV_EN undefined:
  - No divider is synthesized.
  - DIV and MOD return result 0 with div_err=1 regardless of operands.
  - All other opcodes and timing are unchanged.

## Test plan
- Reset mid-sequence:
  - Stimulus: reset_n low during OUT of a 4-instruction run.
  - Response: all outputs take reset values immediately; a new start afterwards runs normally.
- Basic run:
  - Stimulus: slots 0..2 = {ADD,5,3}, {SUB,-7,2}, {MULT,-4,6}; start with first_addr=0, count=3; result_ready=1.
  - Response: results 8, -9, -24 at cycles N+3, N+6, N+9; done at N+10.
- Backpressure:
  - Stimulus: result_ready low for 5 cycles on the first result.
  - Response: result/result_opc stable, read_pointer unchanged, no extra fetch.
- Wrap and count=0:
  - Stimulus A: first_addr=31, count=2. Response: read_pointer shows 31 then 0.
  - Stimulus B: count=0. Response: no result_valid; done pulse one cycle after start.
- Divide cases:
  - Stimulus: {DIV,-7,2}, {MOD,-7,2}, {DIV,9,0}.
  - Response with macro defined: -3, -1, then 0 with div_err=1.
  - Response without macro: all three give 0 with div_err=1.
- Overflow width:
  - Stimulus: {MULT,32'h7FFFFFFF,32'h7FFFFFFF}.
  - Response: 64'h3FFFFFFF00000001.
  - Stimulus: start pulsed while busy. Response: ignored.
